g11620_emu: RTL and testbench

Synthesizable G11620 line-sensor emulator for the sensor side of the `g11620` controller interface. It watches the controller's RESET line, measures each integration window, answers with the AD_SP start pulse after a fixed delay, and streams one line of synthetic pixels. It sits in loopback builds and benches in place of the real sensor plus ADC. It also flags RESET protocol violations.

---
 rtl/g11620_emu.sv | 212 +++++++++++++++++++++
 tb/tb_g11620_emu.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/g11620_emu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : g11620_emu
// Description : G11620 line-sensor emulator: measures RESET integration,
//               answers with AD_SP and streams one synthetic pixel line.
// Revision    : 1.0 - initial release
// ============================================================================
module g11620_emu #(
   parameter logic [8:0]  PIX_NUM   = 9'd511,
   parameter logic [7:0]  SP_DELAY  = 8'd16,
   parameter logic [31:0] MIN_INTEG = 32'd2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        reset_i,
   input  logic [1:0]  mode_i,
   input  logic [15:0] const_i,
   output logic        ad_sp,
   output logic        video_valid,
   output logic [15:0] video_data,
   output logic        video_last,
   output logic [15:0] frame_cnt,
   output logic        proto_err,
   output logic        short_integ,
   output logic        busy
);

   localparam logic [2:0] c_st_idle  = 3'd0;
   localparam logic [2:0] c_st_integ = 3'd1;
   localparam logic [2:0] c_st_delay = 3'd2;
   localparam logic [2:0] c_st_sp    = 3'd3;
   localparam logic [2:0] c_st_read  = 3'd4;

   logic [2:0]  r_state, w_state_nxt;

   logic [31:0] r_integ_cnt, w_integ_cnt_nxt;
   logic [31:0] r_integ_cap, w_integ_cap_nxt;
   logic [7:0]  r_dly_cnt,   w_dly_cnt_nxt;
   logic [8:0]  r_pix_idx,   w_pix_idx_nxt;
   logic [1:0]  r_mode,      w_mode_nxt;
   logic [15:0] r_const,     w_const_nxt;
   logic        r_ad_sp,     w_ad_sp_nxt;
   logic        r_valid,     w_valid_nxt;
   logic [15:0] r_data,      w_data_nxt;
   logic        r_last,      w_last_nxt;
   logic [15:0] r_frame_cnt, w_frame_cnt_nxt;
   logic        r_proto_err, w_proto_err_nxt;
   logic        r_short,     w_short_nxt;
   logic        r_busy;

   logic [8:0]  w_pix_sel;
   logic [15:0] w_pixel;
   logic        w_sp_hit;
   logic        w_line_end;

   function automatic logic [15:0] f_pixel(
      input logic [1:0]  mode,
      input logic [15:0] cval,
      input logic [31:0] cap,
      input logic [15:0] frame,
      input logic [8:0]  idx
   );
      logic [15:0] v;
      case (mode)
         2'd1:    v = (cap > 32'h0000_FFFF) ? 16'hFFFF : cap[15:0];
         2'd2:    v = cval;
         default: v = {7'b0, idx} + frame;
      endcase
      return v;
   endfunction

   assign w_sp_hit   = (r_dly_cnt == SP_DELAY - 8'd1);
   assign w_line_end = (r_pix_idx == PIX_NUM);
   // SP emits pixel 0; READ emits the pixel following the one on the bus
   assign w_pix_sel  = (r_state == c_st_sp) ? 9'd0 : r_pix_idx + 9'd1;
   assign w_pixel    = f_pixel(r_mode, r_const, r_integ_cap, r_frame_cnt, w_pix_sel);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= c_st_idle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_st_idle:  if (reset_i) w_state_nxt = c_st_integ;
         c_st_integ: if (!reset_i) w_state_nxt = c_st_delay;
         c_st_delay: begin
            if (reset_i)       w_state_nxt = c_st_integ;
            else if (w_sp_hit) w_state_nxt = c_st_sp;
         end
         c_st_sp:    w_state_nxt = reset_i ? c_st_integ : c_st_read;
         c_st_read: begin
            if (reset_i)         w_state_nxt = c_st_integ;
            else if (w_line_end) w_state_nxt = c_st_idle;
         end
         default:    w_state_nxt = c_st_idle;
      endcase
   end

   always_comb begin
      w_integ_cnt_nxt = r_integ_cnt;
      w_integ_cap_nxt = r_integ_cap;
      w_dly_cnt_nxt   = r_dly_cnt;
      w_pix_idx_nxt   = r_pix_idx;
      w_mode_nxt      = r_mode;
      w_const_nxt     = r_const;
      w_ad_sp_nxt     = r_ad_sp;
      w_valid_nxt     = r_valid;
      w_data_nxt      = r_data;
      w_last_nxt      = r_last;
      w_frame_cnt_nxt = r_frame_cnt;
      w_proto_err_nxt = 1'b0;
      w_short_nxt     = 1'b0;

      case (r_state)
         c_st_idle: begin
            if (reset_i) w_integ_cnt_nxt = 32'd1;
         end
         c_st_integ: begin
            if (reset_i) begin
               if (r_integ_cnt != 32'hFFFF_FFFF) w_integ_cnt_nxt = r_integ_cnt + 32'd1;
            end else begin
               w_integ_cap_nxt = r_integ_cnt;
               w_short_nxt     = (r_integ_cnt < MIN_INTEG);
               w_dly_cnt_nxt   = 8'd0;
            end
         end
         c_st_delay, c_st_sp, c_st_read: begin
            if (reset_i) begin
               // RESET re-asserted before the line finished: abandon it
               w_proto_err_nxt = 1'b1;
               w_ad_sp_nxt     = 1'b0;
               w_valid_nxt     = 1'b0;
               w_last_nxt      = 1'b0;
               w_integ_cnt_nxt = 32'd1;
            end else if (r_state == c_st_delay) begin
               w_dly_cnt_nxt = r_dly_cnt + 8'd1;
               if (w_sp_hit) begin
                  w_ad_sp_nxt = 1'b1;
                  w_mode_nxt  = mode_i;
                  w_const_nxt = const_i;
               end
            end else if (r_state == c_st_sp) begin
               w_ad_sp_nxt   = 1'b0;
               w_pix_idx_nxt = 9'd0;
               w_valid_nxt   = 1'b1;
               w_data_nxt    = w_pixel;
               w_last_nxt    = (PIX_NUM == 9'd0);
            end else if (w_line_end) begin
               w_valid_nxt     = 1'b0;
               w_last_nxt      = 1'b0;
               w_frame_cnt_nxt = r_frame_cnt + 16'd1;
            end else begin
               w_pix_idx_nxt = w_pix_sel;
               w_data_nxt    = w_pixel;
               w_last_nxt    = (w_pix_sel == PIX_NUM);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_integ_cnt <= 32'd0;
         r_integ_cap <= 32'd0;
         r_dly_cnt   <= 8'd0;
         r_pix_idx   <= 9'd0;
         r_mode      <= 2'd0;
         r_const     <= 16'd0;
         r_ad_sp     <= 1'b0;
         r_valid     <= 1'b0;
         r_data      <= 16'd0;
         r_last      <= 1'b0;
         r_frame_cnt <= 16'd0;
         r_proto_err <= 1'b0;
         r_short     <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_integ_cnt <= w_integ_cnt_nxt;
         r_integ_cap <= w_integ_cap_nxt;
         r_dly_cnt   <= w_dly_cnt_nxt;
         r_pix_idx   <= w_pix_idx_nxt;
         r_mode      <= w_mode_nxt;
         r_const     <= w_const_nxt;
         r_ad_sp     <= w_ad_sp_nxt;
         r_valid     <= w_valid_nxt;
         r_data      <= w_data_nxt;
         r_last      <= w_last_nxt;
         r_frame_cnt <= w_frame_cnt_nxt;
         r_proto_err <= w_proto_err_nxt;
         r_short     <= w_short_nxt;
         r_busy      <= (w_state_nxt != c_st_idle);
      end
   end

   assign ad_sp       = r_ad_sp;
   assign video_valid = r_valid;
   assign video_data  = r_data;
   assign video_last  = r_last;
   assign frame_cnt   = r_frame_cnt;
   assign proto_err   = r_proto_err;
   assign short_integ = r_short;
   assign busy        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_g11620_emu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_g11620_emu
// Description : Self-checking bench for g11620_emu against a line-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_g11620_emu;

   localparam int PN  = 511;
   localparam int SD  = 16;
   localparam int MIN = 2;
   localparam int END_K = SD + PN + 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        reset_i;
   logic [1:0]  mode_i;
   logic [15:0] const_i;
   logic        ad_sp;
   logic        video_valid;
   logic [15:0] video_data;
   logic        video_last;
   logic [15:0] frame_cnt;
   logic        proto_err;
   logic        short_integ;
   logic        busy;

   int          total = 0;
   int          bad   = 0;
   logic [15:0] exp_fc;
   logic [37:0] obs;

   g11620_emu dut (
      .clk         (clk),
      .rst         (rst),
      .reset_i     (reset_i),
      .mode_i      (mode_i),
      .const_i     (const_i),
      .ad_sp       (ad_sp),
      .video_valid (video_valid),
      .video_data  (video_data),
      .video_last  (video_last),
      .frame_cnt   (frame_cnt),
      .proto_err   (proto_err),
      .short_integ (short_integ),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   // pixel data only matters while qualified
   assign obs = {busy, ad_sp, video_valid, video_last, proto_err, short_integ,
                 (video_valid ? video_data : 16'h0), frame_cnt};

   function automatic logic [37:0] pack(input logic b, input logic a, input logic v,
                                        input logic l, input logic pe, input logic si,
                                        input logic [15:0] d, input logic [15:0] fc);
      return {b, a, v, l, pe, si, d, fc};
   endfunction

   function automatic logic [15:0] model_pix(input int j, input logic [1:0] m,
                                             input logic [15:0] c, input longint cap,
                                             input logic [15:0] fc);
      if (m == 2'd1) return (cap > 65535) ? 16'hFFFF : 16'(cap);
      if (m == 2'd2) return c;
      return 16'(j + int'(fc));
   endfunction

   task automatic chk(input string tag, input int k, input logic [37:0] o, input logic [37:0] e);
      total++;
      assert (o === e) else begin
         bad++;
         $error("FAIL %s step=%0d observed=%h expected=%h", tag, k, o, e);
      end
   endtask

   // One integration + line. pre = integration count already accumulated,
   // abort_pix >= 0 raises RESET at that pixel, rst_k >= 0 pulses rst at step k.
   task automatic run_line(input string tag, input int pre, input int len,
                           input logic [1:0] m, input logic [15:0] c,
                           input int abort_pix, input int rst_k);
      longint      cap;
      logic [15:0] fc0;
      logic        v;
      int          j;
      logic [37:0] e;
      cap = longint'(pre + len);
      fc0 = exp_fc;
      reset_i = 1'b1;
      mode_i  = m;
      const_i = c;
      repeat (len) @(negedge clk);
      reset_i = 1'b0;
      for (int k = 0; k <= END_K; k++) begin
         @(negedge clk);
         v = (k >= SD + 1) && (k <= SD + 1 + PN);
         j = k - (SD + 1);
         e = pack(k < END_K, k == SD, v, v && (j == PN), 1'b0,
                  (k == 0) && (cap < MIN),
                  v ? model_pix(j, m, c, cap, fc0) : 16'h0,
                  (k == END_K) ? fc0 + 16'd1 : fc0);
         chk(tag, k, obs, e);
         if (k == SD) begin
            mode_i  = 2'($urandom);
            const_i = 16'($urandom);
         end
         if (abort_pix >= 0 && k == SD + 1 + abort_pix) begin
            reset_i = 1'b1;
            @(negedge clk);
            chk({tag, "_proto"}, k + 1, obs, pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, fc0));
            @(negedge clk);
            chk({tag, "_proto_end"}, k + 2, obs, pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, fc0));
            return;
         end
         if (rst_k >= 0 && k == rst_k) begin
            rst     = 1'b1;
            reset_i = 1'b1;
            @(negedge clk);
            chk({tag, "_rst"}, k + 1, obs, 38'h0);
            chk({tag, "_rst_data"}, k + 1, {22'h0, video_data}, 38'h0);
            rst = 1'b0;
            @(negedge clk);
            chk({tag, "_reenter"}, k + 2, obs, pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0));
            exp_fc = 16'h0;
            return;
         end
      end
      exp_fc = fc0 + 16'd1;
   endtask

   initial begin
      rst     = 1'b1;
      reset_i = 1'b0;
      mode_i  = 2'd0;
      const_i = 16'h0;
      exp_fc  = 16'h0;
      repeat (3) @(negedge clk);
      chk("reset_state", 0, obs, 38'h0);
      chk("reset_data", 0, {22'h0, video_data}, 38'h0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_hold", 0, obs, 38'h0);

      run_line("nominal_m0", 0, 100, 2'd0, 16'h0, -1, -1);
      run_line("m1_300", 0, 300, 2'd1, 16'h1234, -1, -1);
      run_line("m1_sat", 0, 70000, 2'd1, 16'h0, -1, -1);
      for (int i = 0; i < 3; i++) run_line("m2_b2b", 0, 20, 2'd2, 16'hA5A5, -1, -1);
      run_line("short", 0, 1, 2'd1, 16'h0, -1, -1);
      run_line("abort", 0, 40, 2'd0, 16'h0, 200, -1);
      run_line("after_abort", 2, 48, 2'd1, 16'h0, -1, -1);
      run_line("rst_delay", 0, 30, 2'd0, 16'h0, -1, 5);
      run_line("after_rst_delay", 1, 20, 2'd0, 16'h0, -1, -1);
      run_line("rst_read", 0, 30, 2'd2, 16'h5A5A, -1, SD + 1 + 100);
      run_line("after_rst_read", 1, 10, 2'd3, 16'h0, -1, -1);
      for (int i = 0; i < 4; i++) begin
         run_line("random", 0, int'($urandom_range(1, 400)), 2'($urandom_range(0, 3)),
                  16'($urandom), -1, -1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
